// File: rtl/dmem_pkg.sv
// ============================================================================
// Package     : dmem_pkg
// Description : Shared types and constants for the multi-cycle data memory
//               (FSM state encoding, byte-lane count, operation encoding).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    localparam int BYTE_LANES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } dmem_op_e;

endpackage : dmem_pkg

`default_nettype wire

// File: rtl/dmem_byte_array.sv
// ============================================================================
// Module      : dmem_byte_array
// Description : Four byte-wide lanes forming a big-endian 32-bit word RAM.
//               Lane 0 holds bits [31:24] (byte offset 0 within the word).
//               Synchronous whole-word write, combinational read, no reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_byte_array
    import dmem_pkg::*;
#(
    parameter int IDX_W = 5,
    parameter int WORDS = 2 ** IDX_W
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [31:0]      wdata_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [31:0]      rdata_o
);

    logic [7:0] mem_q [BYTE_LANES][WORDS];

    // Commit all four byte lanes of the addressed word when enabled
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int l = 0; l < BYTE_LANES; l++) begin
                mem_q[l][wr_idx_i] <= wdata_i[31-8*l -: 8];
            end
        end
    end

    // Big-endian read assembly: lane l drives byte l counted from the MSB
    for (genvar l = 0; l < BYTE_LANES; l++) begin : g_lane
        assign rdata_o[31-8*l -: 8] = mem_q[l][rd_idx_i];
    end

endmodule : dmem_byte_array

`default_nettype wire

// File: rtl/data_mem_ctrl.sv
// ============================================================================
// Module      : data_mem_ctrl
// Description : Multi-cycle data-memory unit for the MEM stage. Start/Ready
//               handshake, WAIT_CYCLES programmable wait states, big-endian
//               byte-addressed word RAM wrapping modulo DEPTH_BYTES.
//               Optional feature macro: DMEM_ALIGN_CHECK_EN (misaligned
//               accesses are suppressed and flagged on AlignErr).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 128,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        mRD,
    input  logic        mWR,
    input  logic [31:0] DAddr,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        Ready,
    output logic        Busy,
    output logic        AlignErr
);

    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int IDX_W = (AW > 2) ? AW - 2 : 1;

    dmem_state_e      state_q;
    dmem_op_e         op_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      wdata_q;
    logic [3:0]       cnt_q;
    logic             err_q;
    logic [31:0]      dout_q;
    logic             ready_q;
    logic             busy_q;
    logic             align_q;

    logic [IDX_W-1:0] w_idx_in;
    logic [IDX_W-1:0] w_rd_idx;
    logic [31:0]      w_rdata;
    logic             w_req;
    logic             w_err_in;
    logic             w_we;
    dmem_op_e         w_cur_op;
    logic             w_cur_err;
    logic             w_unused_addr;

    // Upper address bits are dropped so accesses wrap modulo DEPTH_BYTES
    assign w_idx_in      = IDX_W'(DAddr >> 2);
    assign w_unused_addr = ^DAddr;
    assign w_req         = mRD | mWR;

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_err_in = (DAddr[1:0] != 2'b00);
`else
    assign w_err_in = 1'b0;
`endif

    // In IDLE the access that may complete immediately (WAIT_CYCLES=0) is the
    // one being accepted, so read address/op/err come straight from the inputs
    assign w_rd_idx  = (state_q == IDLE) ? w_idx_in : idx_q;
    assign w_cur_op  = (state_q == IDLE) ? (mWR ? OP_WR : OP_RD) : op_q;
    assign w_cur_err = (state_q == IDLE) ? w_err_in : err_q;

    // Write commits on the edge that leaves DONE; reset forces IDLE first,
    // which is what cancels an aborted write
    assign w_we = (state_q == DONE) && (op_q == OP_WR) && !err_q;

    dmem_byte_array #(
        .IDX_W (IDX_W)
    ) u_array (
        .clk      (CLK),
        .we_i     (w_we),
        .wr_idx_i (idx_q),
        .wdata_i  (wdata_q),
        .rd_idx_i (w_rd_idx),
        .rdata_o  (w_rdata)
    );

    // Access FSM with wait counter, capture registers and registered outputs
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            op_q    <= OP_RD;
            idx_q   <= '0;
            wdata_q <= '0;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            dout_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            align_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    align_q <= 1'b0;
                    if (w_req) begin
                        op_q    <= w_cur_op;
                        idx_q   <= w_idx_in;
                        wdata_q <= DataIn;
                        err_q   <= w_err_in;
                        busy_q  <= 1'b1;
                        if (WAIT_CYCLES > 0) begin
                            state_q <= WAIT;
                            cnt_q   <= 4'd1;
                        end else begin
                            state_q <= DONE;
                            ready_q <= 1'b1;
                            align_q <= w_cur_err;
                            if (w_cur_op == OP_RD && !w_cur_err) begin
                                dout_q <= w_rdata;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'(WAIT_CYCLES)) begin
                        state_q <= DONE;
                        cnt_q   <= 4'd0;
                        ready_q <= 1'b1;
                        align_q <= w_cur_err;
                        if (w_cur_op == OP_RD && !w_cur_err) begin
                            dout_q <= w_rdata;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    align_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    align_q <= 1'b0;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    assign DataOut  = dout_q;
    assign Ready    = ready_q;
    assign Busy     = busy_q;
    assign AlignErr = align_q;

endmodule : data_mem_ctrl

`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
// ============================================================================
// Module      : tb_data_mem_ctrl
// Description : Self-checking bench for data_mem_ctrl. Expected responses are
//               computed from a word-array model and queued when a request is
//               driven, then popped and compared when Ready is seen.
//               Expectations follow DMEM_ALIGN_CHECK_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_ctrl;

    localparam int DEPTH = 128;
    localparam int WAITC = 1;
    localparam int NWORDS = DEPTH / 4;

    logic        CLK;
    logic        Reset;
    logic        mRD;
    logic        mWR;
    logic [31:0] DAddr;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        Ready;
    logic        Busy;
    logic        AlignErr;

    typedef struct {
        logic [31:0] dout;
        logic        align;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_m [NWORDS];
    logic [31:0] dout_m;
    int          checks;
    int          errors;
    int          ready_pulses;

    data_mem_ctrl #(
        .DEPTH_BYTES (DEPTH),
        .WAIT_CYCLES (WAITC)
    ) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .mRD      (mRD),
        .mWR      (mWR),
        .DAddr    (DAddr),
        .DataIn   (DataIn),
        .DataOut  (DataOut),
        .Ready    (Ready),
        .Busy     (Busy),
        .AlignErr (AlignErr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Count every Ready pulse so aborted accesses can be shown to produce none
    always @(negedge CLK) if (Ready === 1'b1) ready_pulses++;

    // Drive one request, model it, then wait for Ready and check the response
    task automatic do_req(input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] data,
                          input string name);
        exp_t e;
        int   cyc;
        logic got;
        int   idx;
        logic err;
        idx = int'((addr % DEPTH) >> 2);
`ifdef DMEM_ALIGN_CHECK_EN
        err = (addr[1:0] != 2'b00);
`else
        err = 1'b0;
`endif
        if (wr) begin
            if (!err) mem_m[idx] = data;
        end else if (!err) begin
            dout_m = mem_m[idx];
        end
        e.dout  = dout_m;
        e.align = err;
        exp_q.push_back(e);

        @(negedge CLK);
        mRD = rd; mWR = wr; DAddr = addr; DataIn = data;
        @(posedge CLK);
        #1;
        mRD = 1'b0; mWR = 1'b0; DAddr = $urandom; DataIn = $urandom;

        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge CLK);
            cyc++;
            if (cyc == 1) begin
                checks++;
                if (Busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_after_accept: got %b want 1", name, Busy);
                end
            end
            if (Ready === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got || cyc != WAITC + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles (ready=%b) want %0d", name, cyc, got, WAITC + 1);
        end
        e = exp_q.pop_front();
        if (got) begin
            checks++;
            if (DataOut !== e.dout) begin
                errors++;
                $display("FAIL %s dataout: got %h want %h", name, DataOut, e.dout);
            end
            checks++;
            if (AlignErr !== e.align) begin
                errors++;
                $display("FAIL %s alignerr: got %b want %b", name, AlignErr, e.align);
            end
        end
        @(posedge CLK);
        #1;
        checks++;
        if (Ready !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL %s release: got ready=%b busy=%b want 0 0", name, Ready, Busy);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0; mRD = 1'b1; mWR = 1'b0; DAddr = 32'h4; DataIn = 32'h0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (DataOut !== 32'h0 || Ready !== 1'b0 || Busy !== 1'b0 || AlignErr !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got dout=%h rdy=%b busy=%b aerr=%b want 0 0 0 0",
                     DataOut, Ready, Busy, AlignErr);
        end
        mRD = 1'b0;
        @(posedge CLK);
        #1;
        Reset = 1'b1;
        dout_m = 32'h0;
        do_req(1'b0, 1'b1, 32'h0000_0000, 32'h0102_0304, "first_after_reset");
    endtask

    task automatic test_write_read();
        do_req(1'b0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, "wr_08");
        do_req(1'b1, 1'b0, 32'h0000_0008, 32'h0, "rd_08");
        checks++;
        if (dut.u_array.mem_q[0][2] !== 8'hDE) begin
            errors++;
            $display("FAIL byte8_lane: got %h want de", dut.u_array.mem_q[0][2]);
        end
        do_req(1'b1, 1'b0, 32'h0000_0000, 32'h0, "rd_00");
    endtask

    task automatic test_wrap();
        do_req(1'b1, 1'b0, 32'h0000_0088, 32'h0, "rd_88_wrap");
    endtask

    task automatic test_rd_wr_conflict();
        do_req(1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678, "rdwr_10");
        do_req(1'b1, 1'b0, 32'h0000_0010, 32'h0, "rd_10");
    endtask

    // Requests held high while busy must be neither queued nor acted upon
    task automatic test_ignored();
        int cyc;
        do_req(1'b1, 1'b0, 32'h0000_0008, 32'h0, "rd_08_pre");
        @(negedge CLK);
        mRD = 1'b1; DAddr = 32'h0000_0010;
        @(posedge CLK);
        #1;
        mRD = 1'b0;
        mWR = 1'b1; DAddr = 32'h0000_0008; DataIn = 32'h5555_AAAA;
        cyc = 0;
        while (Ready !== 1'b1 && cyc < 20) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
        @(posedge CLK);
        #1;
        mWR = 1'b0;
        dout_m = mem_m[4];
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (Busy !== 1'b0 || DataOut !== dout_m) begin
            errors++;
            $display("FAIL ignored_while_busy: got busy=%b dout=%h want 0 %h", Busy, DataOut, dout_m);
        end
        do_req(1'b1, 1'b0, 32'h0000_0008, 32'h0, "rd_08_untouched");
    endtask

    task automatic test_abort();
        int pulses_before;
        do_req(1'b0, 1'b1, 32'h0000_000C, 32'hCAFE_F00D, "wr_0c");
        pulses_before = ready_pulses;
        @(negedge CLK);
        mWR = 1'b1; DAddr = 32'h0000_000C; DataIn = 32'hFFFF_FFFF;
        @(posedge CLK);
        #1;
        mWR = 1'b0;
        @(negedge CLK);
        Reset = 1'b0;
        #1;
        checks++;
        if (Busy !== 1'b0 || Ready !== 1'b0 || DataOut !== 32'h0) begin
            errors++;
            $display("FAIL abort_reset: got busy=%b rdy=%b dout=%h want 0 0 0", Busy, Ready, DataOut);
        end
        repeat (2) @(posedge CLK);
        #1;
        Reset = 1'b1;
        dout_m = 32'h0;
        repeat (2) @(negedge CLK);
        checks++;
        if (ready_pulses != pulses_before) begin
            errors++;
            $display("FAIL abort_no_ready: got %0d pulses want 0", ready_pulses - pulses_before);
        end
        do_req(1'b1, 1'b0, 32'h0000_000C, 32'h0, "rd_0c_after_abort");
    endtask

    task automatic test_align();
        do_req(1'b0, 1'b1, 32'h0000_000D, 32'hA5A5_5A5A, "wr_0d");
        do_req(1'b1, 1'b0, 32'h0000_000C, 32'h0, "rd_0c_after_0d");
    endtask

    initial begin
        checks = 0; errors = 0; ready_pulses = 0;
        mRD = 1'b0; mWR = 1'b0; DAddr = '0; DataIn = '0; Reset = 1'b0;
        dout_m = 32'h0;
        for (int i = 0; i < NWORDS; i++) mem_m[i] = 'x;
        test_reset();
        test_write_read();
        test_wrap();
        test_rd_wr_conflict();
        test_ignored();
        test_abort();
        test_align();
        repeat (2) @(posedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_data_mem_ctrl

`default_nettype wire
